// File: rtl/sign_extend_pipe_if.sv
// Operand/result handshake bundle for sign_extend_pipe.
// master = producer/consumer side, slave = the extender itself.
interface sign_extend_pipe_if #(
   parameter int unsigned IN_W  = 32,
   parameter int unsigned OUT_W = 64,
   parameter int unsigned FW_W  = $clog2(IN_W) + 1
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  data_in;
   logic [1:0]       mode;
   logic [FW_W-1:0]  field_w;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] data_out;
   logic             mode_err;
   logic [15:0]      count;

   modport master (
      output in_valid, data_in, mode, field_w, out_ready,
      input  in_ready, out_valid, data_out, mode_err, count
   );

   modport slave (
      input  in_valid, data_in, mode, field_w, out_ready,
      output in_ready, out_valid, data_out, mode_err, count
   );
endinterface

// File: rtl/sign_extend_pipe.sv
// Field sign/zero extender with optional branch-offset shift, buffered in a 2-entry FIFO.
// Results are computed at acceptance; in_ready depends only on occupancy.
module sign_extend_pipe #(
   parameter int unsigned IN_W  = 32,
   parameter int unsigned OUT_W = 64,
   parameter int unsigned SHAMT = 2,
   parameter int unsigned FW_W  = $clog2(IN_W) + 1
) (
   input logic               clk,
   input logic               rst_n,
   sign_extend_pipe_if.slave bus
);

   logic [OUT_W-1:0] ext;
   logic             sign;
   logic             fill;
   int               fw;

   // Out-of-range field widths collapse to the full operand width.
   always_comb begin
      ext  = '0;
      sign = 1'b0;
      fw   = int'(bus.field_w);
      if (fw == 0 || fw > int'(IN_W)) fw = int'(IN_W);
      for (int i = 0; i < int'(IN_W); i++) begin
         if (i == fw - 1) sign = bus.data_in[i];
      end
      fill = sign && (bus.mode == 2'd0 || bus.mode == 2'd2);
      for (int i = 0; i < int'(IN_W); i++) begin
         ext[i] = (i < fw) ? bus.data_in[i] : fill;
      end
      for (int i = int'(IN_W); i < int'(OUT_W); i++) begin
         ext[i] = fill;
      end
      if (bus.mode == 2'd2) ext = ext << SHAMT;
   end

   logic [OUT_W:0] mem_q [2];
   logic           wr_ptr_q, rd_ptr_q;
   logic [1:0]     occ_q, occ_d;
   logic [15:0]    count_q;
   logic           armed_q;
   logic           push, pop;

   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;

   always_comb begin
      occ_d = occ_q;
      if (push && !pop)      occ_d = occ_q + 2'd1;
      else if (pop && !push) occ_d = occ_q - 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
         count_q  <= 16'd0;
         armed_q  <= 1'b0;
      end else begin
         armed_q <= 1'b1;
         occ_q   <= occ_d;
         if (push) begin
            mem_q[wr_ptr_q] <= {bus.mode == 2'd3, ext};
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
            count_q  <= count_q + 16'd1;
         end
      end
   end

   // armed_q holds in_ready low through reset and until the first edge after release.
   assign bus.in_ready  = armed_q && (occ_q != 2'd2);
   assign bus.out_valid = (occ_q != 2'd0);
   assign bus.data_out  = mem_q[rd_ptr_q][OUT_W-1:0];
   assign bus.mode_err  = mem_q[rd_ptr_q][OUT_W];
   assign bus.count     = count_q;

endmodule

// File: tb/tb_sign_extend_pipe.sv
// Randomized and directed bench for sign_extend_pipe against a queue-based reference model.
module tb_sign_extend_pipe;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fails;

   sign_extend_pipe_if #(.IN_W(32), .OUT_W(64), .FW_W(6)) bus ();

   sign_extend_pipe #(.IN_W(32), .OUT_W(64), .SHAMT(2), .FW_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: bit 64 = mode_err, bits 63:0 = result.
   function automatic logic [64:0] model(input logic [1:0] m, input int fwin,
                                         input logic [31:0] din);
      int           fw;
      logic [127:0] mask, val;
      logic         neg;
      fw   = (fwin == 0 || fwin > 32) ? 32 : fwin;
      mask = (128'd1 << fw) - 128'd1;
      val  = {96'd0, din} & mask;
      neg  = din[fw-1];
      if ((m == 2'd0 || m == 2'd2) && neg) val = val | ~mask;
      if (m == 2'd2) val = val << 2;
      return {m == 2'd3, val[63:0]};
   endfunction

   logic        armed;
   logic [64:0] q[$];
   logic [15:0] mcount;
   int          pops;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) armed <= 1'b0;
      else        armed <= 1'b1;
   end

   // Compare process: outputs vs model, then commit the transfers seen this cycle.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         mcount = 16'd0;
      end else begin
         check("in_ready", {63'd0, bus.in_ready}, {63'd0, armed && (q.size() < 2)});
         check("out_valid", {63'd0, bus.out_valid}, {63'd0, q.size() != 0});
         check("count", {48'd0, bus.count}, {48'd0, mcount});
         if (bus.out_valid && q.size() != 0) begin
            check("data_out", bus.data_out, q[0][63:0]);
            check("mode_err", {63'd0, bus.mode_err}, {63'd0, q[0][64]});
         end
         if (bus.out_valid && bus.out_ready && q.size() != 0) begin
            void'(q.pop_front());
            mcount = mcount + 16'd1;
            pops++;
         end
         if (bus.in_valid && bus.in_ready)
            q.push_back(model(bus.mode, int'(bus.field_w), bus.data_in));
      end
   end

   task automatic idle_inputs();
      bus.in_valid  = 1'b0;
      bus.data_in   = '0;
      bus.mode      = 2'd0;
      bus.field_w   = '0;
      bus.out_ready = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("rst_count", {48'd0, bus.count}, 64'd0);
      check("rst_data_out", bus.data_out, 64'd0);
      check("rst_mode_err", {63'd0, bus.mode_err}, 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic send_and_check(input string name, input logic [1:0] m, input logic [5:0] fw,
                                 input logic [31:0] din, input logic [63:0] exp,
                                 input logic experr);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.mode     = m;
      bus.field_w  = fw;
      bus.data_in  = din;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      check({name, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
      check(name, bus.data_out, exp);
      check({name, "_err"}, {63'd0, bus.mode_err}, {63'd0, experr});
   endtask

   logic [63:0] held;
   int          wait_cnt;

   initial begin
      n_checks = 0;
      n_fails  = 0;
      pops     = 0;
      rst_n    = 1'b1;
      idle_inputs();
      do_reset();

      // Model pinned against hand-computed values.
      check("model_m0", model(2'd0, 32, 32'h8000_0001)[63:0], 64'hFFFF_FFFF_8000_0001);
      check("model_m2", model(2'd2, 16, 32'h0000_FFFF)[63:0], 64'hFFFF_FFFF_FFFF_FFFC);

      send_and_check("m0_fw32", 2'd0, 6'd32, 32'h8000_0001, 64'hFFFF_FFFF_8000_0001, 1'b0);
      send_and_check("m0_fw12", 2'd0, 6'd12, 32'h0000_0FFE, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
      send_and_check("m1_fw12", 2'd1, 6'd12, 32'h0000_0FFE, 64'h0000_0000_0000_0FFE, 1'b0);
      send_and_check("m2_fw16", 2'd2, 6'd16, 32'h0000_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
      send_and_check("m3_fw16", 2'd3, 6'd16, 32'h0000_FFFF, 64'h0000_0000_0000_FFFF, 1'b1);
      send_and_check("m0_fw0", 2'd0, 6'd0, 32'hFFFF_0000, 64'hFFFF_FFFF_FFFF_0000, 1'b0);
      send_and_check("m0_fw40", 2'd0, 6'd40, 32'h7FFF_FFFF, 64'h0000_0000_7FFF_FFFF, 1'b0);
      send_and_check("m0_fw1", 2'd0, 6'd1, 32'hFFFF_FFFE, 64'h0, 1'b0);
      send_and_check("m1_hi_ign", 2'd1, 6'd4, 32'hFFFF_FFF5, 64'h5, 1'b0);

      // Stall: three offers, two accepted, output held.
      do_reset();
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      bus.mode      = 2'd0;
      bus.field_w   = 6'd8;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.data_in  = 32'h80 + i;
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
      held = bus.data_out;
      check("stall_head", held, 64'hFFFF_FFFF_FFFF_FF80);
      repeat (3) @(negedge clk);
      check("stall_stable", bus.data_out, held);
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("stall_count", {48'd0, bus.count}, 64'd2);

      // Reset with two entries buffered.
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      repeat (2) @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_full", {63'd0, bus.in_ready}, 64'd0);
      bus.out_ready = 1'b1;
      do_reset();
      repeat (4) @(negedge clk);
      check("post_rst_empty", {63'd0, bus.out_valid}, 64'd0);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         bus.mode      = 2'($urandom_range(0, 3));
         bus.field_w   = 6'($urandom_range(0, 40));
         bus.data_in   = $urandom;
      end
      @(posedge clk);
      #1;
      idle_inputs();
      wait_cnt = 0;
      while (bus.out_valid && wait_cnt < 20) begin
         @(posedge clk);
         #1 wait_cnt++;
      end
      check("drain", {63'd0, bus.out_valid}, 64'd0);

      // Back-to-back stream through the count wrap.
      do_reset();
      pops = 0;
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 65537; c++) begin
         bus.mode    = 2'($urandom_range(0, 3));
         bus.field_w = 6'($urandom_range(0, 40));
         bus.data_in = $urandom;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("stream_pops", 64'(pops), 64'd65537);
      check("stream_count_wrap", {48'd0, bus.count}, 64'd1);
      check("stream_empty", {63'd0, bus.out_valid}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/sign_extend_pipe.md
SIGN_EXTEND_PIPE -- requirements
Module: sign_extend_pipe

Parameters
REQ-001 IN_W, default 32, input operand width; legal range 2..64.
REQ-002 OUT_W, default 64, result width; SHALL satisfy OUT_W >= IN_W + SHAMT.
REQ-003 SHAMT, default 2, left-shift amount applied in mode 2 (branch-offset form).
REQ-004 FW_W, default $clog2(IN_W)+1, width of the field_w port.

Interface
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  an operand is offered this cycle.
REQ-008 in_ready  output  1  block accepts an operand this cycle.
REQ-009 data_in  input  IN_W  raw operand.
REQ-010 mode  input  2  0 sign-extend, 1 zero-extend, 2 sign-extend then shift left SHAMT, 3 reserved.
REQ-011 field_w  input  FW_W  number of valid low bits in data_in; the sign bit is bit field_w-1.
REQ-012 out_valid  output  1  a result is presented.
REQ-013 out_ready  input  1  downstream consumes the result this cycle.
REQ-014 data_out  output  OUT_W  extended result.
REQ-015 mode_err  output  1  presented result came from mode 3.
REQ-016 count  output  16  number of results consumed since reset.

Function
REQ-017 Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-018 Effective width fw = field_w, except that field_w == 0 or field_w > IN_W SHALL be treated as IN_W.
REQ-019 Mode 0: data_out[fw-1:0] = data_in[fw-1:0]; bits OUT_W-1..fw = data_in[fw-1].
REQ-020 Mode 1: data_out[fw-1:0] = data_in[fw-1:0]; all higher bits are 0.
REQ-021 Mode 2: data_out = (mode-0 result << SHAMT), truncated to OUT_W; the low SHAMT bits are 0.
REQ-022 Mode 3: data_out = mode-1 result with mode_err = 1; in all other modes mode_err = 0.
REQ-023 Data in data_in bits at or above fw SHALL be ignored.
REQ-024 The result is computed combinationally at acceptance and stored in a 2-entry FIFO holding data_out and mode_err.
REQ-025 Latency: an operand accepted in cycle N SHALL be presented with out_valid = 1 in cycle N+1 at the earliest.
REQ-026 in_ready = 1 when the FIFO holds fewer than 2 entries. in_ready SHALL NOT depend combinationally on out_ready.
REQ-027 When the FIFO is full, a simultaneous pop and push in the same cycle is not possible, because in_ready = 0 when full.
REQ-028 When the FIFO holds 1 entry, a simultaneous push and pop SHALL leave occupancy at 1 and present the new entry next cycle.
REQ-029 When the FIFO is empty, out_valid = 0.
REQ-030 The FIFO SHALL preserve order; results are never dropped or duplicated.
REQ-031 While out_valid = 1 and out_ready = 0, data_out and mode_err SHALL hold stable.
REQ-032 count increments by 1 on every transfer out and wraps from 0xFFFF to 0x0000.

Reset
REQ-033 While rst_n = 0: FIFO empty, out_valid = 0, in_ready = 0, data_out = 0, mode_err = 0, count = 0.
REQ-034 in_ready SHALL rise in the first clk edge after rst_n deasserts.
REQ-035 Reset asserted mid-operation discards all buffered entries immediately; no partial result is emitted after release.

Verification
REQ-036 IN_W=32, OUT_W=64: mode 0, field_w=32, data_in 0x80000001 -> data_out 0xFFFFFFFF80000001 one cycle later.
REQ-037 Mode 0, field_w=12, data_in 0x00000FFE -> 0xFFFFFFFFFFFFFFFE; same stimulus in mode 1 -> 0x0000000000000FFE.
REQ-038 Mode 2, field_w=16, data_in 0x0000FFFF -> 0xFFFFFFFFFFFFFFFC; mode 3 with the same operand -> 0x000000000000FFFF with mode_err = 1.
REQ-039 Hold out_ready = 0 and offer 3 operands -> 2 accepted, then in_ready = 0 and data_out stable; release out_ready -> results appear in order and count = 2.
REQ-040 Pulse rst_n low while 2 entries are buffered -> out_valid = 0 and count = 0 immediately; nothing emitted after release.
REQ-041 Stream 65537 back-to-back transfers with in_valid = out_ready = 1 -> throughput of 1 per cycle and count = 1 after wrap.
